// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: shares one combinational mini-ALU between two requesters.
// A round-robin arbiter grants one request at a time. The granted operands are
// registered towards the ALU, the result is captured one cycle later, and it is
// returned on a single valid/ready response channel tagged with the requester id.
module alu_share_ctrl #(
  parameter int WIDTH = 6,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  // requester 0
  input  logic             req0_valid,
  input  logic [2:0]       req0_fxn,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  // requester 1
  input  logic             req1_valid,
  input  logic [2:0]       req1_fxn,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  // shared ALU
  output logic [2:0]       alu_fxn,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  // response channel
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  input  logic             rsp_ready,
  // status
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic rr_ptr;     // side preferred when both requesters are valid
  logic cur_id;     // id of the operation in flight
  logic any_valid;
  logic grant_id;
  logic accept;
  logic complete;

  // Arbitration: single valid wins outright, a tie goes to the rr_ptr side.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    any_valid = req0_valid | req1_valid;
    grant_id  = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_id = rr_ptr;
    end else if (req1_valid) begin
      grant_id = 1'b1;
    end
    accept   = (state == IDLE) && any_valid;
    complete = (state == RESP) && rsp_ready;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked state uses non-blocking assignments so all registers update together at the edge.
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: one operation in flight, IDLE -> EXEC -> RESP -> IDLE.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (any_valid) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state: ready only for the granted side in IDLE, held low during reset.
  always_comb begin
    req0_ready = rst_n & accept & ~grant_id;
    req1_ready = rst_n & accept &  grant_id;
    busy       = (state != IDLE);
  end

  // Operand registers and arbitration pointer: load only on accept, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_fxn <= '0;
      alu_a   <= '0;
      alu_b   <= '0;
      cur_id  <= 1'b0;
      rr_ptr  <= 1'b0;
    end else if (accept) begin
      alu_fxn <= grant_id ? req1_fxn : req0_fxn;
      alu_a   <= grant_id ? req1_a   : req0_a;
      alu_b   <= grant_id ? req1_b   : req0_b;
      cur_id  <= grant_id;
      rr_ptr  <= ~grant_id;
    end
  end

  // Response registers: capture the ALU result at the end of EXEC, hold until consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
    end else if (state == EXEC) begin
      rsp_valid <= 1'b1;
      rsp_id    <= cur_id;
      rsp_data  <= alu_result;
    end else if (complete) begin
      rsp_valid <= 1'b0;
    end
  end

  // Completed-operation counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count <= '0;
    end else if (complete) begin
      op_count <= op_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: a behavioural ALU drives alu_result, a cycle model of
// the sequencer predicts handshakes, and expected responses go through a scoreboard queue.
module tb_alu_share_ctrl;

  localparam int WIDTH = 6;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req0_valid, req1_valid;
  logic [2:0]       req0_fxn, req1_fxn;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic             req0_ready, req1_ready;
  logic [2:0]       alu_fxn;
  logic [WIDTH-1:0] alu_a, alu_b, alu_result;
  logic             rsp_valid, rsp_id, rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             busy;
  logic [CNT_W-1:0] op_count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_share_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_fxn   (req0_fxn),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_fxn   (req1_fxn),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ready (req1_ready),
    .alu_fxn    (alu_fxn),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_ready  (rsp_ready),
    .busy       (busy),
    .op_count   (op_count)
  );

  // Behavioural mini-ALU: 110 add, 111 subtract, 100 unsigned less-than (zero-extended).
  function automatic logic [WIDTH-1:0] alu_model(input logic [2:0] f,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
    case (f)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a ^ b;
      3'b011:  return ~a;
      3'b100:  return {{(WIDTH-1){1'b0}}, (a < b)};
      3'b101:  return {{(WIDTH-1){1'b0}}, (a == b)};
      3'b110:  return a + b;
      default: return a - b;
    endcase
  endfunction

  always_comb alu_result = alu_model(alu_fxn, alu_a, alu_b);

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Cycle model and scoreboard.
  typedef enum logic [1:0] {M_IDLE, M_EXEC, M_RESP} m_state_t;
  typedef struct packed {
    logic             id;
    logic [WIDTH-1:0] data;
  } exp_t;

  exp_t       sb[$];
  m_state_t   m_state;
  logic       m_rr;
  logic [CNT_W-1:0] m_count;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state <= M_IDLE;
      m_rr    <= 1'b0;
      m_count <= '0;
      sb.delete();
    end else begin
      logic m_any;
      logic m_g;
      exp_t e;
      m_any = (m_state == M_IDLE) && (req0_valid || req1_valid);
      m_g   = (req0_valid && req1_valid) ? m_rr : req1_valid;
      check("busy",      busy,       m_state != M_IDLE);
      check("rsp_valid", rsp_valid,  m_state == M_RESP);
      check("op_count",  op_count,   m_count);
      check("req0_ready", req0_ready, m_any && !m_g);
      check("req1_ready", req1_ready, m_any &&  m_g);
      case (m_state)
        M_IDLE: if (m_any) begin
          e.id   = m_g;
          e.data = m_g ? alu_model(req1_fxn, req1_a, req1_b)
                       : alu_model(req0_fxn, req0_a, req0_b);
          sb.push_back(e);
          m_rr    <= ~m_g;
          m_state <= M_EXEC;
        end
        M_EXEC: m_state <= M_RESP;
        default: begin
          if (sb.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
          end else begin
            check("rsp_id",   rsp_id,   sb[0].id);
            check("rsp_data", rsp_data, sb[0].data);
            if (rsp_ready) begin
              void'(sb.pop_front());
              m_count <= m_count + 1'b1;
              m_state <= M_IDLE;
            end
          end
        end
      endcase
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_alu_fxn"},   alu_fxn,    0);
    check({tag, "_alu_a"},     alu_a,      0);
    check({tag, "_alu_b"},     alu_b,      0);
    check({tag, "_rsp_valid"}, rsp_valid,  0);
    check({tag, "_rsp_id"},    rsp_id,     0);
    check({tag, "_rsp_data"},  rsp_data,   0);
    check({tag, "_busy"},      busy,       0);
    check({tag, "_op_count"},  op_count,   0);
    check({tag, "_ready0"},    req0_ready, 0);
    check({tag, "_ready1"},    req1_ready, 0);
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
  endtask

  // Present one operation and hold it until accepted; returns at accept edge + 1.
  task automatic send(input logic id, input logic [2:0] f,
                      input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic got;
    got = 1'b0;
    @(posedge clk); #1;
    if (id) begin
      req1_valid = 1'b1; req1_fxn = f; req1_a = a; req1_b = b;
    end else begin
      req0_valid = 1'b1; req0_fxn = f; req0_a = a; req0_b = b;
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (id ? req1_ready : req0_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic wait_idle();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (!busy) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) check("idle_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    logic done;
    rsp_ready = 1'b1;
    req0_fxn = '0; req0_a = '0; req0_b = '0;
    req1_fxn = '0; req1_a = '0; req1_b = '0;
    do_reset();

    // Single requests: add, subtract, compare.
    send(1'b0, 3'b110, 6'd5, 6'd3); wait_idle();
    send(1'b1, 3'b111, 6'd3, 6'd5); wait_idle();
    send(1'b1, 3'b100, 6'd2, 6'd7); wait_idle();
    check("op_count_after_3", op_count, 3);

    // Both requesters continuously valid from reset: grants alternate 0,1,0,1.
    do_reset();
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_fxn = 3'b110; req0_a = 6'd1;  req0_b = 6'd2;
    req1_valid = 1'b1; req1_fxn = 3'b111; req1_a = 6'd9;  req1_b = 6'd4;
    done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (op_count == 4) begin
        done = 1'b1;
        break;
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    if (!done) check("rr_timeout", 32'd0, 32'd1);
    check("op_count_rr", op_count, 4);

    // Response back-pressure: hold rsp_ready low for 5 cycles while a new request waits.
    rsp_ready = 1'b0;
    send(1'b1, 3'b010, 6'h2a, 6'h0f);
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_fxn = 3'b000; req0_a = 6'h3c; req0_b = 6'h0f;
    repeat (5) @(posedge clk);
    #1;
    check("bp_busy", busy, 1);
    rsp_ready = 1'b1;
    wait_idle();
    wait_idle();
    req0_valid = 1'b0;

    // Reset during EXEC: everything zero at once, no response afterwards.
    send(1'b0, 3'b110, 6'd7, 6'd7);
    #1;
    rst_n = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    check_all_zero("midreset");
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("post_reset_busy", busy, 0);
    check("post_reset_rsp_valid", rsp_valid, 0);

    // Counter wrap: 255 completions then one more.
    do_reset();
    for (int i = 0; i < 255; i++) begin
      send(1'($urandom_range(1)), 3'($urandom_range(7)),
           6'($urandom_range(63)), 6'($urandom_range(63)));
      wait_idle();
    end
    check("op_count_255", op_count, 255);
    send(1'b0, 3'b001, 6'h11, 6'h22);
    wait_idle();
    check("op_count_wrap", op_count, 0);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
